// File: rtl/colour_pwm_driver.sv
// Three-channel LED driver: fades each channel level toward a colour-derived target
// in STEP increments every FADE_DIV cycles and renders the levels as PWM.
module colour_pwm_driver #(
  parameter int PWM_BITS = 8,
  parameter int FADE_DIV = 4,
  parameter int STEP     = 16
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [2:0] colour,
  output logic       led_r,
  output logic       led_g,
  output logic       led_b,
  output logic       busy,
  output logic       err
);

  localparam int                   PRESC_W    = (FADE_DIV > 1) ? $clog2(FADE_DIV) : 1;
  localparam logic [PWM_BITS-1:0]  MAX        = '1;
  localparam logic [PWM_BITS-1:0]  STEP_V     = PWM_BITS'(STEP);
  localparam logic [PRESC_W-1:0]   PRESC_LAST = PRESC_W'(FADE_DIV - 1);

  typedef enum logic {IDLE, FADE} state_t;

  logic [2:0]                     colour_q, colour_d;
  logic [PRESC_W-1:0]             presc_q, presc_d;
  logic [PWM_BITS-1:0]            pwm_cnt_q, pwm_cnt_d;
  logic [2:0][PWM_BITS-1:0]       level_q, level_d, target;
  logic [2:0]                     led_q, led_d, differ;
  logic                           err_q, err_d;
  logic                           busy_q;
  state_t                         state_q, state_d;
  logic                           tick, col_illegal, in_illegal;

  assign tick        = (presc_q == PRESC_LAST);
  assign col_illegal = (colour_q == 3'b000) || (colour_q == 3'b111);
  assign in_illegal  = (colour == 3'b000) || (colour == 3'b111);

  // Channel index equals its colour bit: 2=R, 1=G, 0=B.
  for (genvar gi = 0; gi < 3; gi++) begin : g_ch
    logic [PWM_BITS-1:0] up_gap, dn_gap;

    assign target[gi] = (colour_q[gi] && !col_illegal) ? MAX : '0;
    assign up_gap     = target[gi] - level_q[gi];
    assign dn_gap     = level_q[gi] - target[gi];
    assign differ[gi] = (level_q[gi] != target[gi]);

    // Clamp the last step so the level lands exactly on its target.
    assign level_d[gi] = !tick                     ? level_q[gi] :
                         (level_q[gi] < target[gi]) ? ((up_gap > STEP_V) ? level_q[gi] + STEP_V : target[gi]) :
                         (level_q[gi] > target[gi]) ? ((dn_gap > STEP_V) ? level_q[gi] - STEP_V : target[gi]) :
                                                      level_q[gi];

    assign led_d[gi] = (level_q[gi] == MAX) || (pwm_cnt_q < level_q[gi]);
  end

  always_comb begin
    colour_d  = colour;
    err_d     = in_illegal && (colour != colour_q);
    presc_d   = tick ? '0 : presc_q + 1'b1;
    pwm_cnt_d = pwm_cnt_q + 1'b1;
    state_d   = state_q;
    case (state_q)
      IDLE:    if (|differ)  state_d = FADE;
      FADE:    if (!(|differ)) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      colour_q  <= 3'b001;
      presc_q   <= '0;
      pwm_cnt_q <= '0;
      level_q   <= '0;
      led_q     <= '0;
      err_q     <= 1'b0;
      busy_q    <= 1'b0;
      state_q   <= IDLE;
    end else begin
      colour_q  <= colour_d;
      presc_q   <= presc_d;
      pwm_cnt_q <= pwm_cnt_d;
      level_q   <= level_d;
      led_q     <= led_d;
      err_q     <= err_d;
      busy_q    <= (state_d == FADE);
      state_q   <= state_d;
    end
  end

  assign led_r = led_q[2];
  assign led_g = led_q[1];
  assign led_b = led_q[0];
  assign busy  = busy_q;
  assign err   = err_q;

endmodule

// File: tb/tb_colour_pwm_driver.sv
// Bench for colour_pwm_driver: cycle-level arithmetic model of the fade/PWM rules,
// per-cycle output comparison, plus directed scenarios with hand-computed literals.
module tb_colour_pwm_driver;

  localparam int MAXV = 255;
  localparam int FDIV = 4;
  localparam int STP  = 16;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic [2:0] colour = 3'b001;
  logic       led_r, led_g, led_b, busy, err;

  logic       rst2_n = 1'b0;
  logic [2:0] colour2 = 3'b001;
  logic       led2_r, led2_g, led2_b, busy2, err2;

  int n_checks = 0;
  int n_pass   = 0;
  logic check_en = 1'b0;

  colour_pwm_driver dut (
    .clk(clk), .rst_n(rst_n), .colour(colour),
    .led_r(led_r), .led_g(led_g), .led_b(led_b), .busy(busy), .err(err)
  );

  // Slow-fade instance so an intermediate level is held long enough to measure duty.
  colour_pwm_driver #(.PWM_BITS(8), .FADE_DIV(1024), .STEP(100)) dut2 (
    .clk(clk), .rst_n(rst2_n), .colour(colour2),
    .led_r(led2_r), .led_g(led2_g), .led_b(led2_b), .busy(busy2), .err(err2)
  );

  initial forever #5 clk = ~clk;

  // ---------------- behavioural model (index = colour bit: 2=R,1=G,0=B) ----------------
  int         m_lvl [3] = '{0, 0, 0};
  logic [2:0] m_col   = 3'b001;
  int         m_presc = 0;
  int         m_pwm   = 0;
  logic [2:0] m_led   = 3'b000;
  logic       m_busy  = 1'b0;
  logic       m_err   = 1'b0;

  function automatic int tgt(input logic [2:0] c, input int ch);
    if (c == 3'b000 || c == 3'b111) return 0;
    return c[ch] ? MAXV : 0;
  endfunction

  initial forever begin
    @(posedge clk or negedge rst_n);
    if (!rst_n) begin
      for (int ch = 0; ch < 3; ch++) m_lvl[ch] = 0;
      m_col = 3'b001; m_presc = 0; m_pwm = 0;
      m_led = 3'b000; m_busy = 1'b0; m_err = 1'b0;
    end else begin
      logic [2:0] led_n;
      logic       busy_n;
      busy_n = 1'b0;
      for (int ch = 0; ch < 3; ch++) begin
        led_n[ch] = (m_lvl[ch] == MAXV) || (m_pwm < m_lvl[ch]);
        if (m_lvl[ch] != tgt(m_col, ch)) busy_n = 1'b1;
      end
      m_err = (colour == 3'b000 || colour == 3'b111) && (colour != m_col);
      if (m_presc == FDIV - 1) begin
        for (int ch = 0; ch < 3; ch++) begin
          int t;
          t = tgt(m_col, ch);
          if (m_lvl[ch] < t) m_lvl[ch] += (t - m_lvl[ch] < STP) ? t - m_lvl[ch] : STP;
          else if (m_lvl[ch] > t) m_lvl[ch] -= (m_lvl[ch] - t < STP) ? m_lvl[ch] - t : STP;
        end
        m_presc = 0;
      end else begin
        m_presc++;
      end
      m_pwm  = (m_pwm + 1) % (MAXV + 1);
      m_col  = colour;
      m_led  = led_n;
      m_busy = busy_n;
    end
  end

  // ---------------- per-cycle compare ----------------
  initial forever begin
    @(negedge clk);
    if (check_en) begin
      n_checks++;
      if ({led_r, led_g, led_b, busy, err} === {m_led, m_busy, m_err}) n_pass++;
      else $display("FAIL cycle_compare t=%0t rgb_busy_err actual=%b expected=%b",
                    $time, {led_r, led_g, led_b, busy, err}, {m_led, m_busy, m_err});
    end
  end

  task automatic chk(input string name, input int act, input int exp);
    n_checks++;
    if (act == exp) n_pass++;
    else $display("FAIL %s actual=%0d expected=%0d", name, act, exp);
  endtask

  task automatic measure(input int n, output int cr, output int cg, output int cb,
                         output int cbusy, output int cerr);
    cr = 0; cg = 0; cb = 0; cbusy = 0; cerr = 0;
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      cr += int'(led_r); cg += int'(led_g); cb += int'(led_b);
      cbusy += int'(busy); cerr += int'(err);
    end
  endtask

  // Called at a negedge with rst_n low and colour=001; releases reset and checks the ramp.
  task automatic ramp_from_reset(input string tag);
    int nb, ne, cr, cg, cb, cbusy, cerr;
    nb = 0; ne = 0;
    rst_n = 1'b1;
    for (int k = 1; k <= 80; k++) begin
      @(negedge clk);
      nb += int'(busy); ne += int'(err);
      if (k == 1)  chk({tag, "_busy_rise"}, int'(busy), 1);
      if (k == 20) chk({tag, "_blue_after_5_ticks"}, m_lvl[0], 80);
      if (k == 60) chk({tag, "_blue_after_15_ticks"}, m_lvl[0], 240);
      if (k == 64) chk({tag, "_blue_after_16_ticks"}, m_lvl[0], 255);
    end
    chk({tag, "_busy_cycles"}, nb, 64);
    chk({tag, "_err_count"}, ne, 0);
    measure(512, cr, cg, cb, cbusy, cerr);
    $display("txn %s: busy_cycles=%0d led_r=%0d led_g=%0d led_b=%0d over 512", tag, nb, cr, cg, cb);
    chk({tag, "_led_r_high"}, cr, 0);
    chk({tag, "_led_g_high"}, cg, 0);
    chk({tag, "_led_b_high"}, cb, 512);
    chk({tag, "_busy_settled"}, cbusy, 0);
  endtask

  initial begin
    int cr, cg, cb, cbusy, cerr, nb;

    repeat (3) @(negedge clk);
    chk("reset_outputs", int'({led_r, led_g, led_b, busy, err}), 0);
    $display("txn reset: outputs=%b", {led_r, led_g, led_b, busy, err});
    check_en = 1'b1;

    // Power-up ramp of blue.
    ramp_from_reset("ramp001");

    // 001 -> 110: crossfade, all channels move on the same ticks.
    colour = 3'b110;
    nb = 0;
    for (int k = 1; k <= 80; k++) begin
      @(negedge clk);
      nb += int'(busy);
      if (k == 4) begin
        chk("xfade_tick1_blue", m_lvl[0], 239);
        chk("xfade_tick1_red", m_lvl[2], 16);
        chk("xfade_tick1_green", m_lvl[1], 16);
      end
    end
    chk("xfade_busy_cycles", nb, 63);
    measure(512, cr, cg, cb, cbusy, cerr);
    $display("txn colour=110: busy_cycles=%0d led_r=%0d led_g=%0d led_b=%0d", nb, cr, cg, cb);
    chk("xfade_led_r_high", cr, 512);
    chk("xfade_led_g_high", cg, 512);
    chk("xfade_led_b_high", cb, 0);

    // Settle at 010, then illegal codes.
    colour = 3'b010;
    repeat (80) @(negedge clk);
    chk("green_settled", m_lvl[1], 255);
    colour = 3'b111;
    @(negedge clk);
    chk("err_enter_111", int'(err), 1);
    measure(79, cr, cg, cb, cbusy, cerr);
    chk("err_single_111", cerr, 0);
    measure(512, cr, cg, cb, cbusy, cerr);
    $display("txn colour=111: led_r=%0d led_g=%0d led_b=%0d err_after=%0d", cr, cg, cb, cerr);
    chk("illegal_leds_off", cr + cg + cb, 0);
    colour = 3'b000;
    @(negedge clk);
    chk("err_111_to_000", int'(err), 1);
    measure(20, cr, cg, cb, cbusy, cerr);
    chk("err_single_000", cerr, 0);
    colour = 3'b001;
    measure(80, cr, cg, cb, cbusy, cerr);
    $display("txn colour=000->001: err_count=%0d", cerr);
    chk("no_err_to_legal", cerr, 0);

    // Asynchronous reset mid-fade, between clock edges.
    colour = 3'b110;
    repeat (10) @(negedge clk);
    chk("midfade_busy_before_reset", int'(busy), 1);
    #2 rst_n = 1'b0;
    #1 chk("async_reset_outputs", int'({led_r, led_g, led_b, busy, err}), 0);
    $display("txn async reset: outputs=%b", {led_r, led_g, led_b, busy, err});
    colour = 3'b001;
    repeat (2) @(negedge clk);
    ramp_from_reset("ramp_after_async");

    // Retarget at blue=128 mid ramp-up.
    rst_n = 1'b0;
    colour = 3'b001;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    repeat (32) @(negedge clk);
    chk("retarget_blue_at_128", m_lvl[0], 128);
    colour = 3'b110;
    repeat (3) @(negedge clk);
    chk("retarget_no_early_tick", m_lvl[0], 128);
    @(negedge clk);
    chk("retarget_blue_112", m_lvl[0], 112);
    chk("retarget_red_16", m_lvl[2], 16);
    chk("retarget_green_16", m_lvl[1], 16);
    $display("txn retarget: r=%0d g=%0d b=%0d", m_lvl[2], m_lvl[1], m_lvl[0]);
    repeat (80) @(negedge clk);

    // Duty of held intermediate levels on the slow instance.
    rst2_n = 1'b1;
    repeat (1030) @(negedge clk);
    cb = 0; cbusy = 0; cr = 0;
    for (int i = 0; i < 512; i++) begin
      @(negedge clk);
      cb += int'(led2_b); cbusy += int'(busy2); cr += int'(led2_r);
    end
    $display("txn duty L=100: led_b_high=%0d of 512", cb);
    chk("duty_level_100", cb, 200);
    chk("duty_red_off", cr, 0);
    chk("duty_busy_held", cbusy, 512);
    repeat (520) @(negedge clk);
    cb = 0;
    for (int i = 0; i < 512; i++) begin
      @(negedge clk);
      cb += int'(led2_b);
    end
    $display("txn duty L=200: led_b_high=%0d of 512", cb);
    chk("duty_level_200", cb, 400);

    check_en = 1'b0;
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
